fifo_write_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of one `fifo` instance between NUM_REQ producers.
- Producers in the bus engine are the UART RX path, the SPI/I2C capture and the ADC sampler.
- Grants are per-burst: a granted requester keeps the port until its last word, a burst-length limit, or valid deassertion. Words of one burst are never interleaved with another requester's words.
- Sits between the producers and the fifo `in_shift`/`in_data`/`in_full` port.

---
 rtl/bp_fifo_pkg.sv | 16 +
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fifo_pkg.sv
// Shared definitions for the fifo-side arbitration blocks of the bus engine.
// Contents:
//   arb_state_t - two-state arbiter FSM encoding (ST_IDLE = 0, ST_BUSY = 1)
//   id_width()  - width of a requester index, $clog2(n) but never below 1
package bp_fifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Scans req starting at rr_ptr and wrapping modulo NUM_REQ; reports the first
// set index. Written standalone so the read-side scheduler can reuse it.
// Ports:
//   req    in  [NUM_REQ-1:0]  request vector
//   rr_ptr in  [ID_W-1:0]     highest-priority index for this scan
//   found  out                at least one request set
//   index  out [ID_W-1:0]     winning index (0 when nothing is found)
module rr_pick
    import bp_fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest set request wins last.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        cand_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            found  = found | req[cand_s];
            index  = req[cand_s] ? cand_s : index;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, per-burst arbiter sharing the single fifo write port between
// NUM_REQ producers (UART RX, SPI/I2C capture, ADC sampler, ...).
// A grant is taken in an IDLE cycle (no transfer that cycle) and held until the
// granted requester sends last, reaches MAX_BURST words, or drops valid.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   req_valid      [NUM_REQ]        per-requester word valid
//   req_last       [NUM_REQ]        per-requester end of burst (with valid)
//   req_data       [NUM_REQ*WIDTH]  packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready      [NUM_REQ]        combinational accept, only the granted bit
//   fifo_in_shift  out              write strobe to fifo in_shift
//   fifo_in_data   [WIDTH] out      write word, zero when not shifting
//   fifo_in_full   in               fifo in_full (registered inside the fifo)
//   grant_id       out              current / most recent granted index
//   busy           out              grant held
module fifo_write_arbiter
    import bp_fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_in_shift,
    output logic [WIDTH-1:0]           fifo_in_data,
    input  logic                       fifo_in_full,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_r;
    arb_state_t         state_next_s;
    logic [NUM_REQ-1:0] grant_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic [ID_W-1:0]    grant_id_r;
    logic               busy_r;

    logic               pick_found_s;
    logic [ID_W-1:0]    pick_index_s;
    logic               cur_valid_s;
    logic               cur_last_s;
    logic [WIDTH-1:0]   cur_data_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               xfer_s;
    logic               release_s;
    logic [ID_W-1:0]    next_ptr_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_r),
        .found  (pick_found_s),
        .index  (pick_index_s)
    );

    // Granted requester's handshake, transfer qualification and release decision.
    always_comb begin
        cur_valid_s = req_valid[grant_id_r];
        cur_last_s  = req_last[grant_id_r];
        cur_data_s  = req_data[int'(grant_id_r) * WIDTH +: WIDTH];
        cnt_inc_s   = burst_cnt_r + CNT_W'(1);
        // reset gates the strobes directly so they drop the instant it rises
        xfer_s      = (state_r == ST_BUSY) && cur_valid_s && !fifo_in_full && !reset;
        if (state_r == ST_BUSY) begin
            // a missing valid releases even while the fifo is stalling us
            release_s = !cur_valid_s ||
                        (xfer_s && (cur_last_s || (cnt_inc_s == CNT_W'(MAX_BURST))));
        end else begin
            release_s = 1'b0;
        end
        if ((state_r == ST_BUSY) && !fifo_in_full && !reset) begin
            req_ready = grant_r;
        end else begin
            req_ready = '0;
        end
        fifo_in_shift = xfer_s;
        fifo_in_data  = xfer_s ? cur_data_s : '0;
        next_ptr_s    = (grant_id_r == ID_W'(NUM_REQ - 1)) ? '0 : (grant_id_r + ID_W'(1));
    end

    // Next-state logic for the IDLE/BUSY arbiter.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (release_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant, round-robin pointer and burst counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
            grant_id_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_r     <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_index_s;
                        grant_id_r  <= pick_index_s;
                        burst_cnt_r <= '0;
                        busy_r      <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (release_s) begin
                        // grant_id keeps the released index until the next grant
                        grant_r  <= '0;
                        busy_r   <= 1'b0;
                        rr_ptr_r <= next_ptr_s;
                    end else if (xfer_s) begin
                        burst_cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = grant_id_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_in_shift;
    logic [W-1:0]   fifo_in_data;
    logic           fifo_in_full;
    logic [1:0]     grant_id;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // producers: words remaining, burst length (0 = never last), position, next word, forced-off
    int         p_left[N];
    int         p_blen[N];
    int         p_pos[N];
    logic [7:0] p_nxt[N];
    bit         p_hold[N];

    // reference model: arbitration state in plain integers
    bit         m_busy;
    int         m_g;
    int         m_ptr;
    int         m_cnt;
    logic [N-1:0] e_ready;
    logic         e_shift;
    logic [W-1:0] e_data;

    // observed DUT activity
    int         log_id[$];
    logic [7:0] log_val[$];
    int         log_cyc[$];
    int         gnt_q[$];
    bit         prev_busy;

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_in_shift (fifo_in_shift),
        .fifo_in_data  (fifo_in_data),
        .fifo_in_full  (fifo_in_full),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] obs_now();
        return {busy, grant_id, req_ready, fifo_in_shift, fifo_in_data};
    endfunction

    function automatic logic [15:0] exp_now();
        return {m_busy, 2'(m_g), e_ready, e_shift, e_data};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic v;
            v = (p_left[i] > 0) && !p_hold[i];
            req_valid[i] = v;
            req_last[i]  = v && (p_blen[i] > 0) && (p_pos[i] == p_blen[i] - 1);
            req_data[i*W +: W] = v ? p_nxt[i] : 8'($urandom);
        end
    endtask

    // expected combinational outputs for the current cycle, sampled mid-cycle
    task automatic eval();
        @(negedge clock);
        e_ready = '0;
        e_shift = 1'b0;
        e_data  = '0;
        if (m_busy && !fifo_in_full) begin
            e_ready[m_g] = 1'b1;
            if (req_valid[m_g]) begin
                e_shift = 1'b1;
                e_data  = req_data[m_g*W +: W];
            end
        end
    endtask

    task automatic advance();
        bit found;
        int idx;
        if (fifo_in_shift) begin
            log_id.push_back(int'(grant_id));
            log_val.push_back(fifo_in_data);
            log_cyc.push_back(cyc);
        end
        if (busy && !prev_busy) gnt_q.push_back(int'(grant_id));
        prev_busy = busy;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin
                    found  = 1'b1;
                    m_busy = 1'b1;
                    m_g    = idx;
                    m_cnt  = 0;
                end
            end
        end else if (!req_valid[m_g]) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % N;
        end else if (e_shift) begin
            m_cnt++;
            if (req_last[m_g] || m_cnt == MB) begin
                m_busy = 1'b0;
                m_ptr  = (m_g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (e_ready[i] && req_valid[i]) begin
                p_nxt[i]++;
                p_left[i]--;
                p_pos[i] = (p_blen[i] > 0 && p_pos[i] == p_blen[i] - 1) ? 0 : p_pos[i] + 1;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic clear_env();
        fifo_in_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_left[i] = 0; p_blen[i] = 0; p_pos[i] = 0; p_nxt[i] = 8'h00; p_hold[i] = 1'b0;
        end
        m_busy = 1'b0; m_g = 0; m_ptr = 0; m_cnt = 0; prev_busy = 1'b0;
        log_id.delete(); log_val.delete(); log_cyc.delete(); gnt_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_env();
        drive();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        req_valid = '1; req_last = '0; req_data = '1; fifo_in_full = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (obs_now() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0000", obs_now());
        end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL reset_idle c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            advance();
        end
    endtask

    task automatic test_single();
        logic [7:0] ev [3];
        ev = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        p_left[2] = 3; p_blen[2] = 3; p_nxt[2] = 8'hA1;
        for (int c = 0; c < 6; c++) begin
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL single c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            advance();
        end
        checks++;
        if (log_val.size() != 3) begin
            errors++;
            $display("FAIL single_count: got %0d want 3", log_val.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (log_id[k] !== 2 || log_val[k] !== ev[k] || log_cyc[k] !== k + 1) begin
                    errors++;
                    $display("FAIL single_word%0d: got id=%0d val=%h cyc=%0d want id=2 val=%h cyc=%0d",
                             k, log_id[k], log_val[k], log_cyc[k], ev[k], k + 1);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd2 || dut.rr_ptr_r !== 2'd3) begin
            errors++;
            $display("FAIL single_after: got busy=%b gid=%0d ptr=%0d want busy=0 gid=2 ptr=3",
                     busy, grant_id, dut.rr_ptr_r);
        end
    endtask

    task automatic test_fairness();
        int order [5];
        order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) begin
            p_left[i] = (i == 0) ? 4 : 2; p_blen[i] = 2; p_nxt[i] = 8'(i * 16);
        end
        for (int c = 0; c < 17; c++) begin
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL fair c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            advance();
        end
        checks++;
        if (gnt_q.size() != 5 || log_id.size() != 10) begin
            errors++;
            $display("FAIL fair_counts: got grants=%0d words=%0d want 5 10", gnt_q.size(), log_id.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (gnt_q[k] !== order[k]) begin
                    errors++;
                    $display("FAIL fair_grant%0d: got %0d want %0d", k, gnt_q[k], order[k]);
                end
            end
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (log_id[k] !== order[k/2] || log_cyc[k] !== 1 + (k/2)*3 + (k%2)) begin
                    errors++;
                    $display("FAIL fair_word%0d: got id=%0d cyc=%0d want id=%0d cyc=%0d",
                             k, log_id[k], log_cyc[k], order[k/2], 1 + (k/2)*3 + (k%2));
                end
            end
        end
    endtask

    task automatic test_burst_limit();
        int eid;
        logic [7:0] evl;
        do_reset();
        p_left[1] = 20; p_blen[1] = 0; p_nxt[1] = 8'h00;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) begin
                p_left[0] = 2; p_blen[0] = 2; p_nxt[0] = 8'hC0;
            end
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL burst c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            advance();
        end
        checks++;
        if (gnt_q.size() != 3 || log_id.size() != 22) begin
            errors++;
            $display("FAIL burst_counts: got grants=%0d words=%0d want 3 22", gnt_q.size(), log_id.size());
        end else begin
            checks++;
            if (gnt_q[0] !== 1 || gnt_q[1] !== 0 || gnt_q[2] !== 1) begin
                errors++;
                $display("FAIL burst_order: got %0d,%0d,%0d want 1,0,1", gnt_q[0], gnt_q[1], gnt_q[2]);
            end
            for (int k = 0; k < 22; k++) begin
                eid = (k >= 16 && k < 18) ? 0 : 1;
                evl = (k < 16) ? 8'(k) : ((k < 18) ? 8'(8'hC0 + k - 16) : 8'(k - 2));
                checks++;
                if (log_id[k] !== eid || log_val[k] !== evl) begin
                    errors++;
                    $display("FAIL burst_word%0d: got id=%0d val=%h want id=%0d val=%h",
                             k, log_id[k], log_val[k], eid, evl);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        p_left[0] = 10; p_blen[0] = 10; p_nxt[0] = 8'h00;
        for (int c = 0; c < 18; c++) begin
            fifo_in_full = (c >= 5 && c < 10);
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL stall c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            if (c >= 5 && c < 10) begin
                checks++;
                if (dut.burst_cnt_r !== 5'd4 || busy !== 1'b1 || req_ready !== 4'b0000) begin
                    errors++;
                    $display("FAIL stall_hold c%0d: got cnt=%0d busy=%b ready=%b want cnt=4 busy=1 ready=0000",
                             c, dut.burst_cnt_r, busy, req_ready);
                end
            end
            advance();
        end
        fifo_in_full = 1'b0;
        checks++;
        if (log_val.size() != 10) begin
            errors++;
            $display("FAIL stall_count: got %0d want 10", log_val.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (log_val[k] !== 8'(k) || log_cyc[k] !== ((k < 4) ? k + 1 : k + 6)) begin
                    errors++;
                    $display("FAIL stall_word%0d: got val=%h cyc=%0d want val=%h cyc=%0d",
                             k, log_val[k], log_cyc[k], 8'(k), (k < 4) ? k + 1 : k + 6);
                end
            end
        end
    endtask

    task automatic test_valid_drop();
        int ei [4];
        logic [7:0] ev [4];
        int ec [4];
        ei = '{3, 3, 1, 1};
        ev = '{8'h30, 8'h31, 8'h10, 8'h11};
        ec = '{1, 2, 5, 6};
        do_reset();
        p_left[3] = 10; p_blen[3] = 0; p_nxt[3] = 8'h30;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) begin
                p_left[1] = 2; p_blen[1] = 2; p_nxt[1] = 8'h10;
            end
            if (c == 3) p_hold[3] = 1'b1;
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL drop c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0 || dut.rr_ptr_r !== 2'd0) begin
                    errors++;
                    $display("FAIL drop_release: got busy=%b ptr=%0d want busy=0 ptr=0", busy, dut.rr_ptr_r);
                end
            end
            advance();
        end
        checks++;
        if (log_id.size() != 4 || gnt_q.size() != 2) begin
            errors++;
            $display("FAIL drop_counts: got words=%0d grants=%0d want 4 2", log_id.size(), gnt_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (log_id[k] !== ei[k] || log_val[k] !== ev[k] || log_cyc[k] !== ec[k]) begin
                    errors++;
                    $display("FAIL drop_word%0d: got id=%0d val=%h cyc=%0d want id=%0d val=%h cyc=%0d",
                             k, log_id[k], log_val[k], log_cyc[k], ei[k], ev[k], ec[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        p_left[2] = 10; p_blen[2] = 0; p_nxt[2] = 8'h70;
        for (int c = 0; c < 3; c++) begin
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL areset_pre c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            advance();
        end
        drive();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0000 || fifo_in_shift !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL areset_now: got busy=%b ready=%b shift=%b gid=%0d want 0 0000 0 0",
                     busy, req_ready, fifo_in_shift, grant_id);
        end
        clear_env();
        drive();
        #3;
        reset = 1'b0;
        @(posedge clock);
        #1;
        cyc = 0;
        p_left[0] = 2; p_blen[0] = 2; p_nxt[0] = 8'h80;
        p_left[3] = 2; p_blen[3] = 2; p_nxt[3] = 8'h90;
        for (int c = 0; c < 8; c++) begin
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                $display("FAIL areset_post c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            advance();
        end
        checks++;
        if (gnt_q.size() != 2 || gnt_q[0] !== 0 || gnt_q[1] !== 3) begin
            errors++;
            $display("FAIL areset_order: got %0d grants first=%0d want 2 grants 0 then 3",
                     gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : -1);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (p_left[i] == 0 && $urandom_range(0, 3) == 0) begin
                    p_left[i] = $urandom_range(1, 24);
                    p_blen[i] = $urandom_range(0, 6);
                    p_pos[i]  = 0;
                    p_nxt[i]  = 8'($urandom);
                end
                p_hold[i] = ($urandom_range(0, 9) == 0);
            end
            fifo_in_full = ($urandom_range(0, 4) == 0);
            drive(); eval();
            checks++;
            if (obs_now() !== exp_now()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random c%0d: got %h want %h", c, obs_now(), exp_now());
            end
            advance();
        end
        fifo_in_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_burst_limit();
        test_full_stall();
        test_valid_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
